// File: rtl/irq_controller16.sv
// 16-line fixed-priority interrupt controller (line 15 highest) with an IDLE/REQ/SERVICE CPU handshake.
// `define IRQ_EDGE_EN for edge-triggered pending bits; default build is level-sensitive. state_dbg: 0=IDLE 1=REQ 2=SERVICE.
module irq_controller16 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] irq,
  input  logic        mask_we,
  input  logic [15:0] mask_in,
  input  logic        int_ack,
  input  logic        eoi,
  output logic        int_req,
  output logic [3:0]  int_vec,
  output logic        busy,
  output logic [15:0] pending,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] sync_q [SYNC_STAGES];
  logic [15:0] sirq;
  logic [15:0] mask;
  logic [15:0] eligible;
  logic [3:0]  winner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sirq = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        mask <= 16'hFFFF;
    else if (mask_we) mask <= mask_in;
  end

`ifdef IRQ_EDGE_EN
  logic [15:0] hist;
  logic [15:0] ack_clr;

  always_comb begin
    ack_clr = '0;
    if (state_q == REQ && int_ack) ack_clr[int_vec] = 1'b1;
  end

  // A new rising edge in the acknowledge cycle must survive the clear, so set is OR'd in last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist    <= '0;
      pending <= '0;
    end else begin
      hist    <= sirq;
      pending <= (pending & ~ack_clr) | (sirq & ~hist);
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= sirq;
  end
`endif

  assign eligible = pending & ~mask;

  always_comb begin
    winner = '0;
    for (int i = 0; i < 16; i++) begin
      if (eligible[i]) winner = 4'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Handshake: int_req is the valid, int_ack the ready; the vector transfers on the edge where both are 1.
  // A request whose line stops being eligible before that edge is withdrawn, ack winning any tie.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|eligible) state_d = REQ;
      REQ: begin
        if (int_ack)                state_d = SERVICE;
        else if (!eligible[int_vec]) state_d = IDLE;
      end
      SERVICE: if (eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The vector is frozen from the IDLE->REQ edge until the next IDLE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            int_vec <= '0;
    else if (state_q == IDLE && |eligible) int_vec <= winner;
  end

  always_comb begin
    int_req   = (state_q == REQ);
    busy      = (state_q != IDLE);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_irq_controller16.sv
// Randomized + directed bench for irq_controller16: a behavioural model predicts each cycle's outputs,
// a negedge monitor pops and compares them.
module tb_irq_controller16;
  localparam int S     = 2;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_SVC  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] irq = '0;
  logic        mask_we = 1'b0;
  logic [15:0] mask_in = '0;
  logic        int_ack = 1'b0;
  logic        eoi = 1'b0;
  logic        int_req;
  logic [3:0]  int_vec;
  logic        busy;
  logic [15:0] pending;
  logic [1:0]  state_dbg;

  irq_controller16 #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .int_ack(int_ack), .eoi(eoi), .int_req(int_req), .int_vec(int_vec),
    .busy(busy), .pending(pending), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [21:0] exp_q[$];
  logic [21:0] mon_w;

  // reference model
  logic [15:0] pipe[$];
  logic [15:0] m_hist, m_pend, m_mask;
  logic [3:0]  m_vec;
  int          m_phase;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_w = exp_q.pop_front();
      chk("int_req", {31'd0, int_req}, {31'd0, mon_w[21]});
      chk("busy",    {31'd0, busy},    {31'd0, mon_w[20]});
      chk("int_vec", {28'd0, int_vec}, {28'd0, mon_w[19:16]});
      chk("pending", {16'd0, pending}, {16'd0, mon_w[15:0]});
    end
  end

  task automatic model_reset();
    pipe.delete();
    repeat (S) pipe.push_back(16'h0000);
    m_hist  = '0;
    m_pend  = '0;
    m_mask  = 16'hFFFF;
    m_vec   = '0;
    m_phase = P_IDLE;
  endtask

  task automatic model_step(input logic [15:0] irq_v, input logic we, input logic [15:0] mi,
                            input logic ack, input logic e);
    logic [15:0] elig, s_cur, clr;
    int win;
    elig  = m_pend & ~m_mask;
    s_cur = pipe[S-1];
    clr   = '0;
    win   = -1;
    for (int i = 15; i >= 0; i--) if (win < 0 && elig[i]) win = i;
    case (m_phase)
      P_IDLE: if (win >= 0) begin m_vec = 4'(win); m_phase = P_REQ; end
      P_REQ: begin
        if (ack) begin m_phase = P_SVC; clr[m_vec] = 1'b1; end
        else if (!elig[m_vec]) m_phase = P_IDLE;
      end
      P_SVC: if (e) m_phase = P_IDLE;
      default: ;
    endcase
`ifdef IRQ_EDGE_EN
    m_pend = (m_pend & ~clr) | (s_cur & ~m_hist);
    m_hist = s_cur;
`else
    m_pend = s_cur | (clr & 16'h0000);
`endif
    if (we) m_mask = mi;
    pipe.push_front(irq_v);
    void'(pipe.pop_back());
  endtask

  task automatic step(input logic [15:0] irq_v, input logic we, input logic [15:0] mi,
                      input logic ack, input logic e);
    irq = irq_v; mask_we = we; mask_in = mi; int_ack = ack; eoi = e;
    model_step(irq_v, we, mi, ack, e);
    @(posedge clk);
    #1;
    exp_q.push_back({m_phase == P_REQ, m_phase != P_IDLE, m_vec, m_pend});
  endtask

  task automatic hold(input logic [15:0] irq_v, input int n);
    for (int i = 0; i < n; i++) step(irq_v, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_req(input logic [15:0] irq_v);
    for (int i = 0; i < 12 && m_phase != P_REQ; i++) step(irq_v, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("wait_req_int_req", {31'd0, int_req}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && !(m_phase == P_IDLE && m_pend == 16'h0); i++)
      step(16'h0, 1'b0, 16'h0, m_phase == P_REQ, m_phase == P_SVC);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1; irq = '0; mask_we = 1'b0; mask_in = '0; int_ack = 1'b0; eoi = 1'b0;
    #1;
    chk("rst_int_req", {31'd0, int_req}, 32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_int_vec", {28'd0, int_vec}, 32'd0);
    chk("rst_pending", {16'd0, pending}, 32'd0);
    chk("rst_state",   {30'd0, state_dbg}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r_irq;
    logic        r_we, r_ack, r_eoi;
    logic [15:0] r_mi;

    model_reset();
    do_reset();

    // first request after unmask: S+2 edges from irq rising
    step(16'h0, 1'b1, 16'h0000, 1'b0, 1'b0);
    repeat (S + 2) step(16'h0008, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("r031_req", {31'd0, int_req}, 32'd1);
    chk("r031_vec", {28'd0, int_vec}, 32'd3);
    chk("r031_pend", {16'd0, pending}, 32'h0008);
    step(16'h0008, 1'b0, 16'h0, 1'b1, 1'b0);
    hold(16'h0, S + 2);
    step(16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    drain();

    // simultaneous 2 and 9: 9 first, one IDLE gap, then 2
    wait_req(16'h0204);
    chk("r032_vec9", {28'd0, int_vec}, 32'd9);
    step(16'h0004, 1'b0, 16'h0, 1'b1, 1'b0);
    hold(16'h0004, S + 2);
    step(16'h0004, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("r032_gap_req", {31'd0, int_req}, 32'd0);
    chk("r032_gap_busy", {31'd0, busy}, 32'd0);
    step(16'h0004, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("r032_req2", {31'd0, int_req}, 32'd1);
    chk("r032_vec2", {28'd0, int_vec}, 32'd2);
    drain();

    // higher-priority line arriving during REQ does not preempt
    wait_req(16'h0010);
    hold(16'h1010, S + 3);
    chk("r033_vec_hold", {28'd0, int_vec}, 32'd4);
    step(16'h1000, 1'b0, 16'h0, 1'b1, 1'b0);
    hold(16'h1000, S + 2);
    step(16'h1000, 1'b0, 16'h0, 1'b0, 1'b1);
    step(16'h1000, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("r033_vec12", {28'd0, int_vec}, 32'd12);
    drain();

    // masking the in-flight line withdraws the request
    wait_req(16'h0020);
    chk("r034_vec5", {28'd0, int_vec}, 32'd5);
    step(16'h0020, 1'b1, 16'h0020, 1'b0, 1'b0);
    chk("r034_req_still", {31'd0, int_req}, 32'd1);
    step(16'h0020, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("r034_req_drop", {31'd0, int_req}, 32'd0);
    chk("r034_busy", {31'd0, busy}, 32'd0);
    chk("r034_pend5", {31'd0, pending[5]}, 32'd1);
    step(16'h0, 1'b1, 16'h0000, 1'b0, 1'b0);
    drain();

`ifdef IRQ_EDGE_EN
    // a new edge landing on the acknowledge cycle keeps the bit pending
    wait_req(16'h0080);
    hold(16'h0, S + 2);
    repeat (S) step(16'h0080, 1'b0, 16'h0, 1'b0, 1'b0);
    step(16'h0080, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("r035_pend7", {31'd0, pending[7]}, 32'd1);
    chk("r035_svc", {31'd0, busy}, 32'd1);
    hold(16'h0, 2);
    step(16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    step(16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("r035_rereq", {28'd0, int_vec}, 32'd7);
    drain();
`endif

    // reset during SERVICE abandons everything and remasks
    wait_req(16'h0001);
    step(16'h0001, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("r036_in_svc", {31'd0, busy}, 32'd1);
    do_reset();
    hold(16'h0001, 8);
    chk("r036_noreq", {31'd0, int_req}, 32'd0);
    step(16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0);
    wait_req(16'h0001);
    chk("r036_vec0", {28'd0, int_vec}, 32'd0);
    drain();

    // random traffic, including stray ack/eoi and mask rewrites
    r_irq = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r_irq[$urandom_range(0, 15)] = ~r_irq[$urandom_range(0, 15)];
      r_we  = ($urandom_range(0, 24) == 0);
      r_mi  = 16'($urandom & $urandom);
      r_ack = (m_phase == P_REQ) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      r_eoi = (m_phase == P_SVC) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      step(r_irq, r_we, r_mi, r_ack, r_eoi);
      if (c == 300) begin
        do_reset();
        step(r_irq, 1'b1, 16'h0000, 1'b0, 1'b0);
      end
    end
    drain();

    @(negedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller16.md
IRQ_CONTROLLER16 -- requirements
Module: irq_controller16

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning number of input synchronizer flops per irq line (legal 2..4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port irq  input  16  asynchronous interrupt request lines; index 15 is highest priority.
REQ-005 SHALL have port mask_we  input  1  mask register write strobe.
REQ-006 SHALL have port mask_in  input  16  new mask value; 1 = line masked.
REQ-007 SHALL have port int_ack  input  1  CPU acknowledge of the presented vector.
REQ-008 SHALL have port eoi  input  1  CPU end-of-interrupt strobe.
REQ-009 SHALL have port int_req  output  1  interrupt request to CPU.
REQ-010 SHALL have port int_vec  output  4  vector of the requested or in-service line.
REQ-011 SHALL have port busy  output  1  high when state is not IDLE.
REQ-012 SHALL have port pending  output  16  current pending register.

Function
REQ-013 SHALL pass each irq bit through SYNC_STAGES flops before any use; sirq denotes the synchronized value.
REQ-014 SHALL load mask from mask_in on a clk edge where mask_we=1; new mask affects eligibility from the next cycle.
REQ-015 SHALL define eligible = pending & ~mask.
REQ-016 SHALL select the highest-index set bit of eligible as the winning vector (fixed priority, 15 highest).
REQ-017 SHALL implement FSM with states IDLE, REQ, SERVICE.
REQ-018 IDLE: if eligible != 0, SHALL latch winner into int_vec and enter REQ next cycle; int_req=1 registered in the same edge.
REQ-019 REQ: int_req and int_vec SHALL stay constant until int_ack; a higher-priority line becoming eligible SHALL NOT change int_vec.
REQ-020 REQ with int_ack=1: SHALL enter SERVICE, drop int_req next cycle, and (edge mode) clear pending[int_vec].
REQ-021 REQ with eligible[int_vec]=0 (masked or withdrawn) and int_ack=0: SHALL return to IDLE and drop int_req next cycle.
REQ-022 REQ with int_ack=1 and eligible[int_vec]=0 in the same cycle: int_ack SHALL win (enter SERVICE).
REQ-023 SERVICE: int_vec SHALL hold the in-service vector; no new request issued; eoi=1 SHALL return to IDLE next cycle.
REQ-024 int_ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-025 Back-to-back: eoi in SERVICE with eligible != 0 SHALL pass through IDLE for exactly one cycle before the next REQ (int_req low at least one cycle).
REQ-026 busy SHALL be 1 in REQ and SERVICE, 0 in IDLE.

Reset
REQ-027 On reset=1, asynchronously: state=IDLE, int_req=0, int_vec=0, busy=0, pending=0, mask=16'hFFFF, all synchronizer and edge-history flops=0.
REQ-028 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the interrupt without further handshake; first request possible SYNC_STAGES+2 cycles after release at earliest.

Configuration
REQ-029 Macro IRQ_EDGE_EN defined: pending[i] SHALL set on sirq[i] 0->1 transition (history flop), clear only on acknowledge per REQ-020; set and clear of the same bit in one cycle SHALL leave it set.
REQ-030 IRQ_EDGE_EN undefined: pending SHALL equal registered sirq (level-sensitive), int_ack SHALL NOT clear it; the device must deassert irq before eoi to avoid re-request.

Verification
REQ-031 Reset, mask_we with mask_in=16'h0000, irq[3]=1 (edge mode) -> int_req=1, int_vec=3 after SYNC_STAGES+2 cycles; pending=16'h0008.
REQ-032 irq[2] and irq[9] rise same cycle, mask=0 -> int_vec=9; after int_ack and eoi, one cycle IDLE, then int_vec=2.
REQ-033 In REQ with int_vec=4, irq[12] rises -> int_vec stays 4 until int_ack; after eoi, int_vec=12.
REQ-034 In REQ with int_vec=5, write mask_in=16'h0020 -> int_req drops next cycle, busy=0, pending[5] stays 1.
REQ-035 Edge mode: irq[7] pulsed again in the same cycle int_ack clears it -> pending[7] remains 1, re-requested after eoi.
REQ-036 Reset asserted during SERVICE -> all outputs to reset values immediately, mask=16'hFFFF, no request until mask rewritten.
